// File: rtl/bpu_gshare_pkg.sv
// Shared types and helpers for the gshare branch prediction unit.
//   ctr_t        : 2-bit saturating direction counter (SNT/WNT/WT/ST)
//   CTR_RESET    : counter value after reset (weakly not-taken)
//   btb_entry_t  : one BTB line {valid, tag, target, is_jmp}
//   sat_update() : next counter value given the resolved outcome
// Tag and target fields are sized for the widest supported address (32 bits);
// the BTB zero-extends narrower values into them, so the struct does not need
// to change when BTB_ENTRIES changes the live tag width.
package bpu_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = WNT;

  localparam int unsigned TAG_MAX_W = 32;
  localparam int unsigned TGT_MAX_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [TGT_MAX_W-1:0] target;
    logic                 is_jmp;
  } btb_entry_t;

  // Saturating increment on taken, saturating decrement on not-taken.
  function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
    ctr_t nxt;
    case (ctr)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = CTR_RESET;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bpu_gshare_if.sv
// Pipeline <-> BPU connection bundle.
//   IF side : pc_i -> hit_o, predicted_pc_o, pht_idx_o
//   EX side : upd_* resolution info -> mispredict_o, redirect_pc_o
//   stats   : stat_ctrl_o, stat_mispred_o (zero unless BPU_STATS_EN)
// master = pipeline, slave = predictor.
interface bpu_gshare_if #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned PHT_IDX_BITS = 8
) ();
  logic [XLEN-1:0]         pc_i;
  logic                    hit_o;
  logic [XLEN-1:0]         predicted_pc_o;
  logic [PHT_IDX_BITS-1:0] pht_idx_o;

  logic                    upd_valid_i;
  logic [XLEN-1:0]         upd_pc_i;
  logic                    upd_is_br_i;
  logic                    upd_is_jmp_i;
  logic                    upd_taken_i;
  logic [XLEN-1:0]         upd_target_i;
  logic                    upd_pred_taken_i;
  logic [XLEN-1:0]         upd_pred_target_i;
  logic [PHT_IDX_BITS-1:0] upd_pht_idx_i;

  logic                    mispredict_o;
  logic [XLEN-1:0]         redirect_pc_o;
  logic [31:0]             stat_ctrl_o;
  logic [31:0]             stat_mispred_o;

  modport master (
    output pc_i, upd_valid_i, upd_pc_i, upd_is_br_i, upd_is_jmp_i, upd_taken_i,
           upd_target_i, upd_pred_taken_i, upd_pred_target_i, upd_pht_idx_i,
    input  hit_o, predicted_pc_o, pht_idx_o, mispredict_o, redirect_pc_o,
           stat_ctrl_o, stat_mispred_o
  );

  modport slave (
    input  pc_i, upd_valid_i, upd_pc_i, upd_is_br_i, upd_is_jmp_i, upd_taken_i,
           upd_target_i, upd_pred_taken_i, upd_pred_target_i, upd_pht_idx_i,
    output hit_o, predicted_pc_o, pht_idx_o, mispredict_o, redirect_pc_o,
           stat_ctrl_o, stat_mispred_o
  );
endinterface

// File: rtl/bpu_gshare_btb.sv
// Direct-mapped branch target buffer: asynchronous read, synchronous write,
// asynchronous clear.
//   clk_i, rst_ni         : clock, async active-low reset (clears all entries)
//   rd_pc                 : lookup PC -> rd_hit, rd_target, rd_is_jmp
//   wr_en, wr_pc,
//   wr_target, wr_is_jmp  : allocate/overwrite the line selected by wr_pc
// Index = pc[log2(ENTRIES)+1:2]; tag = everything above the index.
module bpu_btb
  import bpu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] rd_pc,
  output logic            rd_hit,
  output logic [XLEN-1:0] rd_target,
  output logic            rd_is_jmp,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_pc,
  input  logic [XLEN-1:0] wr_target,
  input  logic            wr_is_jmp
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  btb_entry_t mem_r [ENTRIES];
  btb_entry_t rd_entry_s;

  // Tag is the PC with the word offset and index stripped off.
  function automatic logic [TAG_MAX_W-1:0] tag_of(input logic [XLEN-1:0] pc);
    return TAG_MAX_W'(pc >> (IDX_W + 2));
  endfunction

  // Storage: clear on reset, write the addressed line on a taken resolution.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en) begin
      mem_r[wr_pc[IDX_W+1:2]] <= '{valid:  1'b1,
                                   tag:    tag_of(wr_pc),
                                   target: TGT_MAX_W'(wr_target),
                                   is_jmp: wr_is_jmp};
    end
  end

  // Read port: no bypass, a same-cycle write is seen only after the edge.
  always_comb begin
    rd_entry_s = mem_r[rd_pc[IDX_W+1:2]];
    rd_hit     = rd_entry_s.valid & (rd_entry_s.tag == tag_of(rd_pc));
    rd_target  = rd_entry_s.target[XLEN-1:0];
    rd_is_jmp  = rd_entry_s.is_jmp;
  end

endmodule

// File: rtl/bpu_gshare_chk.sv
// Protocol checker for the EX resolution port.
//   clk_i, rst_ni           : clock, async active-low reset
//   upd_valid, is_br, is_jmp: a resolved instruction is either a branch or a jump
module bpu_gshare_chk (
  input logic clk_i,
  input logic rst_ni,
  input logic upd_valid,
  input logic is_br,
  input logic is_jmp
);

  a_br_jmp_exclusive: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(upd_valid && is_br && is_jmp)
  );

endmodule

// File: rtl/bpu_gshare.sv
// gshare branch prediction unit for a 5-stage RV32I pipeline.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : bpu_gshare_if.slave -- IF lookup (pc_i -> hit_o, predicted_pc_o,
//            pht_idx_o), EX resolution (upd_* -> mispredict_o, redirect_pc_o)
//            and statistics (stat_ctrl_o, stat_mispred_o).
// Lookup is purely combinational from registered state. The PHT index
// (pc[PHT_IDX_BITS+1:2] ^ GHR) travels down the pipe so EX trains the exact
// counter that produced the prediction. GHR_BITS = 0 gives a bimodal predictor.
// Optional feature macro: BPU_STATS_EN enables the two 32-bit wrapping
// statistics counters; otherwise the stat outputs are tied to zero.
module bpu_gshare
  import bpu_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned BTB_ENTRIES  = 32,
  parameter int unsigned PHT_IDX_BITS = 8,
  parameter int unsigned GHR_BITS     = 8
) (
  input logic        clk_i,
  input logic        rst_ni,
  bpu_gshare_if.slave bus
);

  localparam int              PHT_SIZE = 2 ** PHT_IDX_BITS;
  localparam int unsigned     GHR_W    = (GHR_BITS == 0) ? 1 : GHR_BITS;
  localparam logic [XLEN-1:0] PC_INC   = {{(XLEN-3){1'b0}}, 3'b100};

  ctr_t                    pht_r [PHT_SIZE];
  logic [GHR_W-1:0]        ghr_r;
  logic [GHR_W-1:0]        ghr_nxt_s;
  logic [PHT_IDX_BITS-1:0] ghr_ext_s;
  logic [PHT_IDX_BITS-1:0] lk_idx_s;
  ctr_t                    lk_ctr_s;
  logic                    btb_hit_s;
  logic [XLEN-1:0]         btb_target_s;
  logic                    btb_is_jmp_s;
  logic                    hit_s;
  logic                    misp_s;
  logic                    btb_wr_s;
  logic                    pht_wr_s;

  bpu_btb #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .rd_pc     (bus.pc_i),
    .rd_hit    (btb_hit_s),
    .rd_target (btb_target_s),
    .rd_is_jmp (btb_is_jmp_s),
    .wr_en     (btb_wr_s),
    .wr_pc     (bus.upd_pc_i),
    .wr_target (bus.upd_target_i),
    .wr_is_jmp (bus.upd_is_jmp_i)
  );

  bpu_gshare_chk u_chk (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .upd_valid (bus.upd_valid_i),
    .is_br     (bus.upd_is_br_i),
    .is_jmp    (bus.upd_is_jmp_i)
  );

  // Lookup path: gshare index, counter read, taken decision.
  always_comb begin
    ghr_ext_s = {PHT_IDX_BITS{1'b0}};
    if (GHR_BITS != 0) begin
      ghr_ext_s[GHR_W-1:0] = ghr_r;
    end else begin
      ghr_ext_s = {PHT_IDX_BITS{1'b0}};
    end
    lk_idx_s = bus.pc_i[PHT_IDX_BITS+1:2] ^ ghr_ext_s;
    lk_ctr_s = pht_r[lk_idx_s];
    // Jumps are always taken once in the BTB; branches follow the counter MSB.
    hit_s    = btb_hit_s & (btb_is_jmp_s | lk_ctr_s[1]);
  end

  // Resolution path: misprediction detect and training enables.
  always_comb begin
    // Forced low during reset so a stray update cannot redirect fetch.
    misp_s    = rst_ni & bus.upd_valid_i &
                ((bus.upd_taken_i != bus.upd_pred_taken_i) |
                 (bus.upd_taken_i & (bus.upd_target_i != bus.upd_pred_target_i)));
    btb_wr_s  = bus.upd_valid_i & bus.upd_taken_i;
    pht_wr_s  = bus.upd_valid_i & bus.upd_is_br_i;
    ghr_nxt_s = (GHR_BITS == 0) ? {GHR_W{1'b0}}
                                : ((ghr_r << 1) | GHR_W'(bus.upd_taken_i));
  end

  // Direction state: PHT counters and global history, trained by branches only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < PHT_SIZE; i++) begin
        pht_r[i] <= CTR_RESET;
      end
      ghr_r <= {GHR_W{1'b0}};
    end else if (pht_wr_s) begin
      pht_r[bus.upd_pht_idx_i] <= sat_update(pht_r[bus.upd_pht_idx_i], bus.upd_taken_i);
      ghr_r                    <= ghr_nxt_s;
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] stat_ctrl_r;
  logic [31:0] stat_mispred_r;

  // Statistics: resolved control instructions and mispredictions, wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_ctrl_r    <= 32'd0;
      stat_mispred_r <= 32'd0;
    end else if (bus.upd_valid_i) begin
      stat_ctrl_r <= stat_ctrl_r + 32'd1;
      if (misp_s) begin
        stat_mispred_r <= stat_mispred_r + 32'd1;
      end
    end
  end
`endif

  // Output drive.
  always_comb begin
    bus.hit_o          = hit_s;
    bus.predicted_pc_o = hit_s ? btb_target_s : (bus.pc_i + PC_INC);
    bus.pht_idx_o      = lk_idx_s;
    bus.mispredict_o   = misp_s;
    bus.redirect_pc_o  = (bus.upd_valid_i & bus.upd_taken_i) ? bus.upd_target_i
                                                             : (bus.upd_pc_i + PC_INC);
`ifdef BPU_STATS_EN
    bus.stat_ctrl_o    = stat_ctrl_r;
    bus.stat_mispred_o = stat_mispred_r;
`else
    bus.stat_ctrl_o    = 32'd0;
    bus.stat_mispred_o = 32'd0;
`endif
  end

endmodule
